// File: rtl/seed_block_serializer.sv
// Parallel-in, byte-serial-out feeder for the 8-bit SEED datapath.
// Optional macro SEED_SER_MSB_FIRST_EN selects MSB-first emission (default LSB-first).
module seed_block_serializer #(
  parameter  int WORDS  = 4,
  localparam int NBYTES = 4 * WORDS,
  localparam int IDX_W  = $clog2(4 * WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [32*WORDS-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_word_end,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state;
  logic [32*WORDS-1:0]   r_shift;
  logic [IDX_W-1:0]      r_count;

  logic                  w_send;
  logic                  w_out_fire;
  logic                  w_last;
  logic                  w_in_ready;
  logic                  w_load;
  logic [32*WORDS-1:0]   w_shift_next;

  assign w_send     = (r_state == S_SEND);
  assign w_out_fire = w_send & out_ready;
  assign w_last     = w_send & (r_count == IDX_W'(NBYTES - 1));
  // Accepting on the final-byte handshake lets blocks stream with no idle bubble.
  assign w_in_ready = ~w_send | (w_out_fire & w_last);
  assign w_load     = in_valid & w_in_ready;

`ifdef SEED_SER_MSB_FIRST_EN
  assign w_shift_next = {r_shift[32*WORDS-9:0], 8'h00};
  assign out_byte     = r_shift[32*WORDS-1:32*WORDS-8];
`else
  assign w_shift_next = {8'h00, r_shift[32*WORDS-1:8]};
  assign out_byte     = r_shift[7:0];
`endif

  assign in_ready     = w_in_ready;
  assign out_valid    = w_send;
  assign busy         = w_send;
  assign out_idx      = r_count;
  assign out_word_end = w_send & (r_count[1:0] == 2'd3);
  assign out_last     = w_last;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_shift <= in_data;
            r_count <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_out_fire) begin
            if (w_load) begin
              r_shift <= in_data;
              r_count <= '0;
            end else if (w_last) begin
              r_shift <= w_shift_next;
              r_count <= '0;
              r_state <= S_IDLE;
            end else begin
              r_shift <= w_shift_next;
              r_count <= r_count + IDX_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_block_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, scored against a
// byte-queue model of the block stream.
module tb_seed_block_serializer;

  localparam int WORDS  = 4;
  localparam int NBYTES = 4 * WORDS;
  localparam int IDX_W  = $clog2(NBYTES);

  logic                clk = 1'b0;
  logic                reset;
  logic [32*WORDS-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          out_byte;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_idx;
  logic                out_word_end;
  logic                out_last;
  logic                busy;

  seed_block_serializer #(.WORDS(WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_word_end (out_word_end),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: every accepted block becomes NBYTES entries in emission order.
  typedef struct packed {
    logic [7:0] b;
    int         idx;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;
  bit   exp_in_ready;
  exp_t e;

  task automatic push_block(input logic [32*WORDS-1:0] d);
    exp_t x;
    for (int i = 0; i < NBYTES; i++) begin
`ifdef SEED_SER_MSB_FIRST_EN
      x.b = d[8*(NBYTES-1-i) +: 8];
`else
      x.b = d[8*i +: 8];
`endif
      x.idx = i;
      q.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_in_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready});
      if (q.size() != 0) begin
        e = q[0];
        check("out_byte", {24'd0, out_byte}, {24'd0, e.b});
        check("out_idx", 32'(out_idx), e.idx);
        check("out_word_end", {31'd0, out_word_end}, {31'd0, (e.idx % 4) == 3});
        check("out_last", {31'd0, out_last}, {31'd0, e.idx == NBYTES - 1});
      end else begin
        check("idle_word_end", {31'd0, out_word_end}, 32'd0);
        check("idle_last", {31'd0, out_last}, 32'd0);
      end
      if (reset) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_in_ready) push_block(in_data);
      end
    end
  end

  task automatic send_block(input logic [32*WORDS-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("send_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_idx shows the requested index.
  task automatic wait_idx(input int idx);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_valid && 32'(out_idx) == idx) begin ok = 1'b1; break; end
    end
    check("wait_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!out_valid && q.size() == 0) begin ok = 1'b1; break; end
    end
    check("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  localparam logic [127:0] BLK_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] BLK_B = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    repeat (3) @(negedge clk);
    check("rst_out_byte", {24'd0, out_byte}, 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Full block at full rate
    send_block(BLK_A);
    drain();
    @(posedge clk); #1;

    // Backpressure at idx 5
    send_block(BLK_A);
    wait_idx(5);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_idx", 32'(out_idx), 32'd5);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("after_hold_idx", 32'(out_idx), 32'd6);
    drain();
    @(posedge clk); #1;

    // Back-to-back blocks
    send_block(BLK_A);
    in_valid = 1'b1;
    in_data  = BLK_B;
    wait_idx(NBYTES - 1);
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_idx0", 32'(out_idx), 32'd0);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    drain();
    @(posedge clk); #1;

    // Reset mid-block
    send_block(BLK_A);
    wait_idx(7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send_block(BLK_B);
    drain();

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0; out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
